// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: datapath widths, ALU opcodes and the packed
// decode control bundle carried from ID into EX.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_NOR = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h7;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h8;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 4'h9;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 4'hA;

  typedef struct packed {
    logic alu_src;
    logic reg_dst;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  // A bubble carries no side effects: every control bit is cleared.
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decode inputs, write-back bypass inputs, hazard
// controls and the registered execute-stage outputs.
interface id_ex_stage_reg_if #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int REG_W   = pipe_pkg::REG_W,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W,
  parameter int PERF_W  = 16
);

  logic               Stall;
  logic               Flush;

  logic               ID_Valid;
  logic [DATA_W-1:0]  ID_Pc;
  logic [DATA_W-1:0]  ID_RsData;
  logic [DATA_W-1:0]  ID_RtData;
  logic [DATA_W-1:0]  ID_Imm;
  logic [REG_W-1:0]   ID_Rs;
  logic [REG_W-1:0]   ID_Rt;
  logic [REG_W-1:0]   ID_Rd;
  logic [ALUOP_W-1:0] ID_AluOp;
  logic               ID_AluSrc;
  logic               ID_RegDst;
  logic               ID_MemRead;
  logic               ID_MemWrite;
  logic               ID_RegWrite;
  logic               ID_MemToReg;

  logic               WB_RegWrite;
  logic [REG_W-1:0]   WB_Rd;
  logic [DATA_W-1:0]  WB_Data;

  logic               EX_Valid;
  logic [DATA_W-1:0]  EX_Pc;
  logic [DATA_W-1:0]  EX_RsData;
  logic [DATA_W-1:0]  EX_RtData;
  logic [DATA_W-1:0]  EX_Imm;
  logic [REG_W-1:0]   EX_Rs;
  logic [REG_W-1:0]   EX_Rt;
  logic [REG_W-1:0]   EX_Rd;
  logic [ALUOP_W-1:0] EX_AluOp;
  logic               EX_AluSrc;
  logic               EX_RegDst;
  logic               EX_MemRead;
  logic               EX_MemWrite;
  logic               EX_RegWrite;
  logic               EX_MemToReg;

  logic [PERF_W-1:0]  BubbleCount;

  modport master (
    output Stall, Flush,
    output ID_Valid, ID_Pc, ID_RsData, ID_RtData, ID_Imm,
    output ID_Rs, ID_Rt, ID_Rd, ID_AluOp,
    output ID_AluSrc, ID_RegDst, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemToReg,
    output WB_RegWrite, WB_Rd, WB_Data,
    input  EX_Valid, EX_Pc, EX_RsData, EX_RtData, EX_Imm,
    input  EX_Rs, EX_Rt, EX_Rd, EX_AluOp,
    input  EX_AluSrc, EX_RegDst, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemToReg,
    input  BubbleCount
  );

  modport slave (
    input  Stall, Flush,
    input  ID_Valid, ID_Pc, ID_RsData, ID_RtData, ID_Imm,
    input  ID_Rs, ID_Rt, ID_Rd, ID_AluOp,
    input  ID_AluSrc, ID_RegDst, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemToReg,
    input  WB_RegWrite, WB_Rd, WB_Data,
    output EX_Valid, EX_Pc, EX_RsData, EX_RtData, EX_Imm,
    output EX_Rs, EX_Rt, EX_Rd, EX_AluOp,
    output EX_AluSrc, EX_RegDst, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemToReg,
    output BubbleCount
  );

endinterface

// File: rtl/id_ex_stage_reg_wb_bypass_cmp.sv
// Write-back compare-and-select: substitutes the value being written back
// this cycle when it targets the given register (never $0).
module wb_bypass_cmp #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_W  = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0]  rs,
  input  logic [DATA_W-1:0] rdata,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] dout
);

  logic hit;

  assign hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == rs);
  assign dout = hit ? wb_data : rdata;

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with stall, flush and write-back
// operand fix-up. Define ID_EX_PERF_EN to build the saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int REG_W   = pipe_pkg::REG_W,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W,
  parameter int PERF_W  = 16
) (
  input logic             Clk,
  input logic             Rst,
  id_ex_stage_reg_if.slave bus
);

  import pipe_pkg::ctrl_t;
  import pipe_pkg::BUBBLE;

  logic               ex_valid;
  logic [DATA_W-1:0]  ex_pc;
  logic [DATA_W-1:0]  ex_rs_data;
  logic [DATA_W-1:0]  ex_rt_data;
  logic [DATA_W-1:0]  ex_imm;
  logic [REG_W-1:0]   ex_rs;
  logic [REG_W-1:0]   ex_rt;
  logic [REG_W-1:0]   ex_rd;
  logic [ALUOP_W-1:0] ex_aluop;
  ctrl_t              ex_ctrl;
  ctrl_t              id_ctrl;

  logic [DATA_W-1:0]  ld_rs_data;
  logic [DATA_W-1:0]  ld_rt_data;
  logic [DATA_W-1:0]  rf_rs_data;
  logic [DATA_W-1:0]  rf_rt_data;
  logic               rf_wb_regwrite;
  logic               take_bubble;

  assign id_ctrl = '{alu_src:    bus.ID_AluSrc,
                     reg_dst:    bus.ID_RegDst,
                     mem_read:   bus.ID_MemRead,
                     mem_write:  bus.ID_MemWrite,
                     reg_write:  bus.ID_RegWrite,
                     mem_to_reg: bus.ID_MemToReg};

  // The register file reads stale data when WB writes the same register in
  // the same cycle, so operands are patched here on load.
  wb_bypass_cmp #(.DATA_W(DATA_W), .REG_W(REG_W)) u_ld_rs (
    .rs          (bus.ID_Rs),
    .rdata       (bus.ID_RsData),
    .wb_regwrite (bus.WB_RegWrite),
    .wb_rd       (bus.WB_Rd),
    .wb_data     (bus.WB_Data),
    .dout        (ld_rs_data)
  );

  wb_bypass_cmp #(.DATA_W(DATA_W), .REG_W(REG_W)) u_ld_rt (
    .rs          (bus.ID_Rt),
    .rdata       (bus.ID_RtData),
    .wb_regwrite (bus.WB_RegWrite),
    .wb_rd       (bus.WB_Rd),
    .wb_data     (bus.WB_Data),
    .dout        (ld_rt_data)
  );

  // A held instruction would otherwise miss a write-back that retires while
  // it waits; only a real instruction is refreshed.
  assign rf_wb_regwrite = bus.WB_RegWrite && ex_valid;

  wb_bypass_cmp #(.DATA_W(DATA_W), .REG_W(REG_W)) u_rf_rs (
    .rs          (ex_rs),
    .rdata       (ex_rs_data),
    .wb_regwrite (rf_wb_regwrite),
    .wb_rd       (bus.WB_Rd),
    .wb_data     (bus.WB_Data),
    .dout        (rf_rs_data)
  );

  wb_bypass_cmp #(.DATA_W(DATA_W), .REG_W(REG_W)) u_rf_rt (
    .rs          (ex_rt),
    .rdata       (ex_rt_data),
    .wb_regwrite (rf_wb_regwrite),
    .wb_rd       (bus.WB_Rd),
    .wb_data     (bus.WB_Data),
    .dout        (rf_rt_data)
  );

  // An invalid decode slot loads the same canonical bubble as a flush.
  assign take_bubble = bus.Flush || (!bus.Stall && !bus.ID_Valid);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_aluop   <= '0;
      ex_ctrl    <= BUBBLE;
    end else if (take_bubble) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_aluop   <= '0;
      ex_ctrl    <= BUBBLE;
    end else if (bus.Stall) begin
      ex_rs_data <= rf_rs_data;
      ex_rt_data <= rf_rt_data;
    end else begin
      ex_valid   <= 1'b1;
      ex_pc      <= bus.ID_Pc;
      ex_rs_data <= ld_rs_data;
      ex_rt_data <= ld_rt_data;
      ex_imm     <= bus.ID_Imm;
      ex_rs      <= bus.ID_Rs;
      ex_rt      <= bus.ID_Rt;
      ex_rd      <= bus.ID_Rd;
      ex_aluop   <= bus.ID_AluOp;
      ex_ctrl    <= id_ctrl;
    end
  end

  assign bus.EX_Valid    = ex_valid;
  assign bus.EX_Pc       = ex_pc;
  assign bus.EX_RsData   = ex_rs_data;
  assign bus.EX_RtData   = ex_rt_data;
  assign bus.EX_Imm      = ex_imm;
  assign bus.EX_Rs       = ex_rs;
  assign bus.EX_Rt       = ex_rt;
  assign bus.EX_Rd       = ex_rd;
  assign bus.EX_AluOp    = ex_aluop;
  assign bus.EX_AluSrc   = ex_ctrl.alu_src;
  assign bus.EX_RegDst   = ex_ctrl.reg_dst;
  assign bus.EX_MemRead  = ex_ctrl.mem_read;
  assign bus.EX_MemWrite = ex_ctrl.mem_write;
  assign bus.EX_RegWrite = ex_ctrl.reg_write;
  assign bus.EX_MemToReg = ex_ctrl.mem_to_reg;

`ifdef ID_EX_PERF_EN
  logic [PERF_W-1:0] bubble_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bubble_cnt <= '0;
    end else if (bus.Flush && (bubble_cnt != {PERF_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + PERF_W'(1);
    end
  end

  assign bus.BubbleCount = bubble_cnt;
`else
  assign bus.BubbleCount = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (small PERF_W so the
// bubble counter saturation is reachable).
module tb_id_ex_stage_reg;

  localparam int PW = 3;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  id_ex_stage_reg_if #(.PERF_W(PW)) bus ();

  id_ex_stage_reg #(.PERF_W(PW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.Stall       = 1'b0;
    bus.Flush       = 1'b0;
    bus.ID_Valid    = 1'b0;
    bus.ID_Pc       = '0;
    bus.ID_RsData   = '0;
    bus.ID_RtData   = '0;
    bus.ID_Imm      = '0;
    bus.ID_Rs       = '0;
    bus.ID_Rt       = '0;
    bus.ID_Rd       = '0;
    bus.ID_AluOp    = '0;
    bus.ID_AluSrc   = 1'b0;
    bus.ID_RegDst   = 1'b0;
    bus.ID_MemRead  = 1'b0;
    bus.ID_MemWrite = 1'b0;
    bus.ID_RegWrite = 1'b0;
    bus.ID_MemToReg = 1'b0;
    bus.WB_RegWrite = 1'b0;
    bus.WB_Rd       = '0;
    bus.WB_Data     = '0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    drive_idle();
    #12;
    checks++;
    if ({bus.EX_Valid, bus.EX_Pc, bus.EX_RsData, bus.EX_RegWrite} !== '0) begin
      errors++;
      $display("FAIL reset_image got valid=%b pc=%h rs=%h rw=%b exp all 0",
               bus.EX_Valid, bus.EX_Pc, bus.EX_RsData, bus.EX_RegWrite);
    end
    checks++;
    if (bus.BubbleCount !== 3'd0) begin
      errors++;
      $display("FAIL reset_bubblecount got %0d exp 0", bus.BubbleCount);
    end
    Rst = 1'b0;
    // load something, then assert reset between edges
    bus.ID_Valid = 1'b1;
    bus.ID_RsData = 32'h0000_1234;
    bus.ID_MemWrite = 1'b1;
    tick();
    checks++;
    if (bus.EX_RsData !== 32'h0000_1234) begin
      errors++;
      $display("FAIL reset_preload got %h exp 00001234", bus.EX_RsData);
    end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({bus.EX_Valid, bus.EX_RsData, bus.EX_MemWrite} !== '0) begin
      errors++;
      $display("FAIL reset_async got valid=%b rs=%h mw=%b exp 0 0 0",
               bus.EX_Valid, bus.EX_RsData, bus.EX_MemWrite);
    end
    // reset held across an edge with stall asserted: no residual hold
    bus.Stall = 1'b1;
    tick();
    checks++;
    if ({bus.EX_Valid, bus.EX_RsData} !== '0) begin
      errors++;
      $display("FAIL reset_over_stall got valid=%b rs=%h exp 0 0", bus.EX_Valid, bus.EX_RsData);
    end
    Rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_load();
    bus.ID_Valid    = 1'b1;
    bus.ID_Pc       = 32'h0000_0100;
    bus.ID_Rs       = 5'd3;
    bus.ID_RsData   = 32'hAAAA_0001;
    bus.ID_Rt       = 5'd4;
    bus.ID_RtData   = 32'h0000_0022;
    bus.ID_Rd       = 5'd9;
    bus.ID_Imm      = 32'hFFFF_FFF0;
    bus.ID_AluOp    = 4'h2;
    bus.ID_RegWrite = 1'b1;
    bus.ID_AluSrc   = 1'b1;
    bus.ID_MemToReg = 1'b1;
    tick();
    checks++;
    if (bus.EX_RsData !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL load_rsdata got %h exp aaaa0001", bus.EX_RsData);
    end
    checks++;
    if ({bus.EX_Valid, bus.EX_AluOp, bus.EX_RegWrite} !== {1'b1, 4'h2, 1'b1}) begin
      errors++;
      $display("FAIL load_ctrl got valid=%b aluop=%h rw=%b exp 1 2 1",
               bus.EX_Valid, bus.EX_AluOp, bus.EX_RegWrite);
    end
    checks++;
    if ({bus.EX_Pc, bus.EX_Imm, bus.EX_Rs, bus.EX_Rt, bus.EX_Rd, bus.EX_RtData} !==
        {32'h0000_0100, 32'hFFFF_FFF0, 5'd3, 5'd4, 5'd9, 32'h0000_0022}) begin
      errors++;
      $display("FAIL load_fields got pc=%h imm=%h rs=%0d rt=%0d rd=%0d rt_data=%h exp 100 fffffff0 3 4 9 22",
               bus.EX_Pc, bus.EX_Imm, bus.EX_Rs, bus.EX_Rt, bus.EX_Rd, bus.EX_RtData);
    end
    checks++;
    if ({bus.EX_AluSrc, bus.EX_RegDst, bus.EX_MemRead, bus.EX_MemWrite, bus.EX_MemToReg} !== 5'b10001) begin
      errors++;
      $display("FAIL load_bits got %b exp 10001",
               {bus.EX_AluSrc, bus.EX_RegDst, bus.EX_MemRead, bus.EX_MemWrite, bus.EX_MemToReg});
    end
    // invalid decode slot loads as bubble
    bus.ID_Valid = 1'b0;
    tick();
    checks++;
    if ({bus.EX_Valid, bus.EX_RsData, bus.EX_Pc, bus.EX_RegWrite, bus.EX_AluOp, bus.EX_Rs} !== '0) begin
      errors++;
      $display("FAIL load_invalid got valid=%b rs=%h pc=%h rw=%b aluop=%h rs_id=%0d exp all 0",
               bus.EX_Valid, bus.EX_RsData, bus.EX_Pc, bus.EX_RegWrite, bus.EX_AluOp, bus.EX_Rs);
    end
    drive_idle();
  endtask

  task automatic test_stall();
    bus.ID_Valid    = 1'b1;
    bus.ID_Pc       = 32'h0000_0200;
    bus.ID_Rs       = 5'd1;
    bus.ID_RsData   = 32'h0000_0011;
    bus.ID_MemWrite = 1'b1;
    tick();
    bus.Stall       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ID_Pc       = 32'h0000_0300 + 32'(i);
      bus.ID_RsData   = 32'h0000_0099;
      bus.ID_MemWrite = 1'b0;
      tick();
      checks++;
      if ({bus.EX_Pc, bus.EX_RsData, bus.EX_MemWrite, bus.EX_Valid} !==
          {32'h0000_0200, 32'h0000_0011, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got pc=%h rs=%h mw=%b v=%b exp 200 11 1 1",
                 i, bus.EX_Pc, bus.EX_RsData, bus.EX_MemWrite, bus.EX_Valid);
      end
    end
    bus.Stall = 1'b0;
    tick();
    checks++;
    if ({bus.EX_Pc, bus.EX_RsData, bus.EX_MemWrite} !== {32'h0000_0302, 32'h0000_0099, 1'b0}) begin
      errors++;
      $display("FAIL stall_release got pc=%h rs=%h mw=%b exp 302 99 0",
               bus.EX_Pc, bus.EX_RsData, bus.EX_MemWrite);
    end
    drive_idle();
  endtask

  task automatic test_flush_beats_stall();
    bus.ID_Valid    = 1'b1;
    bus.ID_Pc       = 32'h0000_0400;
    bus.ID_RsData   = 32'h0000_0077;
    bus.ID_MemWrite = 1'b1;
    tick();
    checks++;
    if (bus.EX_MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup got mw=%b exp 1", bus.EX_MemWrite);
    end
    bus.Stall = 1'b1;
    bus.Flush = 1'b1;
    tick();
    checks++;
    if ({bus.EX_Valid, bus.EX_MemWrite, bus.EX_RsData, bus.EX_Pc} !== '0) begin
      errors++;
      $display("FAIL flush_beats_stall got v=%b mw=%b rs=%h pc=%h exp 0 0 0 0",
               bus.EX_Valid, bus.EX_MemWrite, bus.EX_RsData, bus.EX_Pc);
    end
    drive_idle();
  endtask

  task automatic test_wb_fixup();
    bus.ID_Valid    = 1'b1;
    bus.ID_Rs       = 5'd5;
    bus.ID_RsData   = 32'h0000_0001;
    bus.ID_Rt       = 5'd6;
    bus.ID_RtData   = 32'h0000_0066;
    bus.WB_RegWrite = 1'b1;
    bus.WB_Rd       = 5'd5;
    bus.WB_Data     = 32'h0000_BEEF;
    tick();
    checks++;
    if ({bus.EX_RsData, bus.EX_RtData} !== {32'h0000_BEEF, 32'h0000_0066}) begin
      errors++;
      $display("FAIL wb_fix_rs got rs=%h rt=%h exp beef 66", bus.EX_RsData, bus.EX_RtData);
    end
    bus.ID_Rs = 5'd0;
    bus.WB_Rd = 5'd0;
    tick();
    checks++;
    if (bus.EX_RsData !== 32'h0000_0001) begin
      errors++;
      $display("FAIL wb_fix_r0 got %h exp 00000001", bus.EX_RsData);
    end
    bus.ID_Rs   = 5'd8;
    bus.ID_Rt   = 5'd8;
    bus.WB_Rd   = 5'd8;
    bus.WB_Data = 32'h0000_CAFE;
    tick();
    checks++;
    if ({bus.EX_RsData, bus.EX_RtData} !== {32'h0000_CAFE, 32'h0000_CAFE}) begin
      errors++;
      $display("FAIL wb_fix_both got rs=%h rt=%h exp cafe cafe", bus.EX_RsData, bus.EX_RtData);
    end
    bus.WB_RegWrite = 1'b0;
    tick();
    checks++;
    if ({bus.EX_RsData, bus.EX_RtData} !== {32'h0000_0001, 32'h0000_0066}) begin
      errors++;
      $display("FAIL wb_fix_nowrite got rs=%h rt=%h exp 1 66", bus.EX_RsData, bus.EX_RtData);
    end
    // held-operand refresh during stall
    bus.ID_Rs     = 5'd2;
    bus.ID_RsData = 32'h0000_0020;
    bus.ID_Rt     = 5'd7;
    bus.ID_RtData = 32'h0000_0010;
    tick();
    bus.Stall       = 1'b1;
    bus.WB_RegWrite = 1'b1;
    bus.WB_Rd       = 5'd7;
    bus.WB_Data     = 32'h0000_0055;
    tick();
    checks++;
    if ({bus.EX_RtData, bus.EX_RsData} !== {32'h0000_0055, 32'h0000_0020}) begin
      errors++;
      $display("FAIL stall_refresh_rt got rt=%h rs=%h exp 55 20", bus.EX_RtData, bus.EX_RsData);
    end
    bus.WB_Rd   = 5'd2;
    bus.WB_Data = 32'h0000_0A0A;
    tick();
    checks++;
    if ({bus.EX_RtData, bus.EX_RsData} !== {32'h0000_0055, 32'h0000_0A0A}) begin
      errors++;
      $display("FAIL stall_refresh_rs got rt=%h rs=%h exp 55 a0a", bus.EX_RtData, bus.EX_RsData);
    end
    drive_idle();
    // $0 held in EX is never refreshed
    bus.ID_Valid  = 1'b1;
    bus.ID_Rs     = 5'd0;
    bus.ID_RsData = 32'h0000_0003;
    tick();
    bus.Stall       = 1'b1;
    bus.WB_RegWrite = 1'b1;
    bus.WB_Rd       = 5'd0;
    bus.WB_Data     = 32'hDEAD_DEAD;
    tick();
    checks++;
    if (bus.EX_RsData !== 32'h0000_0003) begin
      errors++;
      $display("FAIL stall_refresh_r0 got %h exp 00000003", bus.EX_RsData);
    end
    drive_idle();
  endtask

  task automatic test_perf();
    Rst = 1'b1;
    #1 Rst = 1'b0;
    bus.Flush = 1'b1;
    repeat (5) tick();
`ifdef ID_EX_PERF_EN
    checks++;
    if (bus.BubbleCount !== 3'd5) begin
      errors++;
      $display("FAIL perf_count5 got %0d exp 5", bus.BubbleCount);
    end
    repeat (4) tick();
    checks++;
    if (bus.BubbleCount !== 3'd7) begin
      errors++;
      $display("FAIL perf_saturate got %0d exp 7", bus.BubbleCount);
    end
    bus.Flush = 1'b0;
    tick();
    checks++;
    if (bus.BubbleCount !== 3'd7) begin
      errors++;
      $display("FAIL perf_hold got %0d exp 7", bus.BubbleCount);
    end
    Rst = 1'b1;
    #1;
    checks++;
    if (bus.BubbleCount !== 3'd0) begin
      errors++;
      $display("FAIL perf_clear got %0d exp 0", bus.BubbleCount);
    end
    Rst = 1'b0;
`else
    checks++;
    if (bus.BubbleCount !== 3'd0) begin
      errors++;
      $display("FAIL perf_disabled got %0d exp 0", bus.BubbleCount);
    end
    repeat (4) tick();
    checks++;
    if (bus.BubbleCount !== 3'd0) begin
      errors++;
      $display("FAIL perf_disabled_long got %0d exp 0", bus.BubbleCount);
    end
`endif
    drive_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_stall();
    test_flush_beats_stall();
    test_wb_fixup();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
